weight_loader: RTL and testbench
================================

# weight_loader

Serial weight writer that fills the per-node weight shift registers of the neural-network top level. It accepts a stream of fixed-point weight words over a valid/ready handshake and drives the top level's shared `bus` and one-hot `we` vector, one word per cycle. Order is node by node, starting at the first node of the first hidden layer. It sits between the host/ROM weight source and the network top.

## Interface
Parameters:
- `sx`, 99, network input count (fan-in of layer 1)
- `sl1`, 99, node count of hidden layer 1 (fan-in of layer 2)
- `sl`, 99, node count of output layer
- `nd`, 99, total nodes; must equal `sl1+sl`
- word width `n` comes from the `` `n `` macro in the fixed-point header; it is not a parameter

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a full load
- `in_data`  in  n (signed)  weight word
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  loader accepts a word this cycle
- `bus`  out  n (signed)  weight word to the network
- `we`  out  nd  one-hot shift enable, bit `nd-1` = layer-1 node 0
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle pulse with the final `we` beat

## Operation
- FSM states and transitions:
  - IDLE -> LOAD on `start`.
  - LOAD -> IDLE on the handshake of the last word.
  - `start` in LOAD is ignored.
- Handshake: a word transfers when `in_valid && in_ready`. `in_ready = (state==LOAD)`.
- Node counter `node`:
  - Initialised to `nd-1` on `start`.
  - Decrements to 0.
- Word counter `wcnt`:
  - Counts 0..fanin-1, then resets and `node` decrements.
  - `fanin = sx` for `node >= sl` (layer 1); `fanin = sl1` otherwise (layer 2).
- Total words `wt = sl1*sx + sl*sl1`.
- Per transfer, registered at the same edge:
  - `bus <= in_data`
  - `we <= 1 << node`
- `we` is all-zero in every cycle without a preceding transfer, including stalls. `bus` holds its last value.
- `done` registers high at the edge of the last transfer.
- Counter widths are `$clog2` of the maximum value plus 1. No wrap is possible: the load stops at `node==0`, `wcnt==fanin-1`.

## Timing
- Reset values: `we=0`, `bus=0`, `busy=0`, `done=0`, `in_ready=0`; state IDLE; counters 0.
- `start` at cycle c: `busy` and `in_ready` are high from cycle c+1.
- Transfer in cycle k: `we`/`bus` are valid in cycle k+1 only. The network shifts at the end of cycle k+1. Latency is 1.
- Full throughput is one word per cycle. With continuous `in_valid`, the load spans cycles c+1..c+wt and `done` is high in cycle c+wt+1.
- `busy` falls in the cycle after the last transfer, together with `done`.
- `rst` mid-load:
  - Next cycle: `we=0`, `busy=0`, state IDLE.
  - Partially loaded registers are not cleared. A new `start` reloads all nodes from scratch.
- `start` in the same cycle as `rst`: reset wins.

## Configuration
- `WEIGHT_LOADER_BIAS_EN` defined:
  - Each node receives `fanin+1` words; the extra last word per node is its bias.
  - `wt` increases by `nd`.
  - Use only with bias-capable layers.
- Undefined: exactly `fanin` words per node.

## Structure
- Shared header/package holds:
  - `` `n `` and the fixed-point format
  - a `fanin(node)` constant function
  - the `wt` total-word formula
- One sub-module, `onehot_dec`: node index to `nd`-bit one-hot, combinational, parameterised by `nd`.
- FSM, counters and output registers live in `weight_loader`.

## Test plan
Test configuration: `sx=2`, `sl1=3`, `sl=2`, `nd=5`, `wt=12`.

1. Reset: after `rst`, `we=5'b0`, `bus=0`, `busy=0`, `done=0`, `in_ready=0`. `in_valid=1` without `start` -> no `we` ever.
2. Full load, `start` at cycle 0, `in_valid` held high, data 1..12 -> `we` sequence:
   - 10000 in cycles 2-3
   - 01000 in cycles 4-5
   - 00100 in cycles 6-7
   - 00010 in cycles 8-10
   - 00001 in cycles 11-13
   - `bus` = 1..12 in step
   - `done` in cycle 13; `busy` is 0 in cycle 13
3. Stall: drop `in_valid` for 3 cycles after word 5 -> `we=0` in those cycles; word 6 goes to node 2 with `we=00100`; `done` is delayed by 3.
4. `start` pulsed again at cycle 6 -> ignored; sequence identical to scenario 2.
5. `rst` at cycle 5, then `start` -> next cycle `we=0`, `busy=0`; reload begins at node 4 with `we=10000`.
6. `WEIGHT_LOADER_BIAS_EN` -> 17 words; node 4 gets 3 beats, node 0 gets 4; `done` in cycle 18.

Source files
------------

// File: rtl/weight_loader_pkg.sv
// Shared definitions for the serial weight loader.
// Word width comes from WL_N; WEIGHT_LOADER_BIAS_EN adds a bias word.
`ifndef WL_N
`define WL_N 16
`endif

package weight_loader_pkg;

  localparam int N = `WL_N;

`ifdef WEIGHT_LOADER_BIAS_EN
  localparam int BIAS = 1;
`else
  localparam int BIAS = 0;
`endif

  typedef enum logic {
    IDLE,
    LOAD
  } state_e;

  function automatic int fanin(int node, int sx, int sl1, int sl);
    return (node >= sl) ? sx : sl1;
  endfunction

  function automatic int wt(int sx, int sl1, int sl, int nd);
    return sl1 * sx + sl * sl1 + BIAS * nd;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Node index to one-hot shift-enable decoder.
// Purely combinational; out-of-range indices give all zeros.
module onehot_dec #(
    parameter int nd = 5,
    parameter int NW = 3
) (
    input  logic [NW-1:0] idx_i,
    output logic [nd-1:0] oh_o
);

    // Compare the index against every bit position.
    always_comb begin
        oh_o = '0;
        for (int i = 0; i < nd; i++) begin
            oh_o[i] = (idx_i == NW'(i));
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Serial weight writer: streams words into per-node shift registers.
// Optional macro WEIGHT_LOADER_BIAS_EN appends one bias word per node.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int sx  = 99,
    parameter int sl1 = 99,
    parameter int sl  = 99,
    parameter int nd  = 99
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [N-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [N-1:0] bus,
    output logic [nd-1:0]       we,
    output logic                busy,
    output logic                done
);

    localparam int MAXF = ((sx > sl1) ? sx : sl1) + BIAS;
    localparam int NW   = $clog2(nd - 1) + 1;
    localparam int WW   = $clog2(MAXF - 1) + 1;

    state_e             state_q, state_d;
    logic [NW-1:0]      node_q, node_d;
    logic [WW-1:0]      wcnt_q, wcnt_d;
    logic signed [N-1:0] bus_q, bus_d;
    logic [nd-1:0]      we_q, we_d;
    logic               done_q, done_d;
    logic [nd-1:0]      node_oh;
    logic [WW-1:0]      wlast;

    onehot_dec #(
        .nd(nd),
        .NW(NW)
    ) u_dec (
        .idx_i(node_q),
        .oh_o (node_oh)
    );

    assign wlast    = WW'(fanin(int'(node_q), sx, sl1, sl) + BIAS - 1);
    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q == LOAD);
    assign bus      = bus_q;
    assign we       = we_q;
    assign done     = done_q;

    // Next-state: start a load, or step word/node counters per transfer.
    always_comb begin
        state_d = state_q;
        node_d  = node_q;
        wcnt_d  = wcnt_q;
        bus_d   = bus_q;
        we_d    = '0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    node_d  = NW'(nd - 1);
                    wcnt_d  = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    bus_d = in_data;
                    we_d  = node_oh;
                    if (wcnt_q == wlast) begin
                        wcnt_d = '0;
                        if (node_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            node_d = node_q - 1'b1;
                        end
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            node_q  <= '0;
            wcnt_q  <= '0;
            bus_q   <= '0;
            we_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            wcnt_q  <= wcnt_d;
            bus_q   <= bus_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader (sx=2, sl1=3, sl=2, nd=5).
// Honours WEIGHT_LOADER_BIAS_EN in its reference model.
module tb_weight_loader;
    import weight_loader_pkg::*;

    localparam int SX  = 2;
    localparam int SL1 = 3;
    localparam int SL  = 2;
    localparam int ND  = 5;
    localparam int WT  = wt(SX, SL1, SL, ND);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic signed [N-1:0] in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [N-1:0] bus;
    logic [ND-1:0]       we;
    logic                busy;
    logic                done;

    int checks = 0;
    int errors = 0;

    // Reference model state: list of destination nodes, one per word.
    int            seqn[$];
    bit            mload = 1'b0;
    int            idx = 0;
    logic [ND-1:0] e_we = '0;
    logic [N-1:0]  e_bus = '0;
    bit            e_done = 1'b0;

    weight_loader #(
        .sx (SX),
        .sl1(SL1),
        .sl (SL),
        .nd (ND)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .bus     (bus),
        .we      (we),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance past the edge, update the model.
    task automatic step(input bit st, input bit v, input bit r,
                        input logic [N-1:0] d);
        start    = st;
        in_valid = v;
        rst      = r;
        in_data  = d;
        @(posedge clk);
        #1;
        if (r) begin
            mload  = 1'b0;
            e_we   = '0;
            e_bus  = '0;
            e_done = 1'b0;
        end else begin
            e_we   = '0;
            e_done = 1'b0;
            if (mload) begin
                if (v) begin
                    e_we  = ND'(1) << seqn[idx];
                    e_bus = d;
                    idx++;
                    if (idx == WT) begin
                        mload  = 1'b0;
                        e_done = 1'b1;
                    end
                end
            end else if (st) begin
                mload = 1'b1;
                idx   = 0;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 8; c++) begin
            step(1'b0, c >= 2, c < 2, N'($urandom));
            checks++;
            if ({we, bus, done, busy, in_ready} !==
                {e_we, e_bus, e_done, mload, mload}) begin
                errors++;
                $display("FAIL reset c=%0d got we=%b bus=%0h d=%b b=%b r=%b want we=%b bus=%0h d=%b b=%b",
                         c, we, bus, done, busy, in_ready,
                         e_we, e_bus, e_done, mload);
            end
        end
    endtask

    task automatic test_full_load();
        int dcyc = -1;
        step(1'b1, 1'b0, 1'b0, '0);
        for (int c = 1; c <= WT + 3; c++) begin
            step(1'b0, c <= WT, 1'b0, N'(c));
            checks++;
            if ({we, bus, done, busy, in_ready} !==
                {e_we, e_bus, e_done, mload, mload}) begin
                errors++;
                $display("FAIL full_load cyc=%0d got we=%b bus=%0d d=%b b=%b want we=%b bus=%0d d=%b b=%b",
                         c + 1, we, bus, done, busy, in_ready,
                         e_we, e_bus, e_done, mload);
            end
            if (c == 1) begin
                checks++;
                if (we !== ND'(1) << (ND - 1)) begin
                    errors++;
                    $display("FAIL full_load_first got we=%b want %b",
                             we, ND'(1) << (ND - 1));
                end
            end
            if (done && dcyc < 0) dcyc = c + 1;
        end
        checks++;
        if (dcyc != WT + 1) begin
            errors++;
            $display("FAIL full_load_done got cycle %0d want %0d",
                     dcyc, WT + 1);
        end
    endtask

    task automatic test_stall();
        int dcyc = -1;
        int w = 0;
        step(1'b1, 1'b0, 1'b0, '0);
        for (int c = 1; c <= WT + 6; c++) begin
            bit v;
            v = (c <= 5) || (c >= 9);
            if (v) w++;
            step(1'b0, v, 1'b0, N'($urandom));
            checks++;
            if ({we, bus, done, busy, in_ready} !==
                {e_we, e_bus, e_done, mload, mload}) begin
                errors++;
                $display("FAIL stall cyc=%0d got we=%b bus=%0h d=%b b=%b want we=%b bus=%0h d=%b b=%b",
                         c + 1, we, bus, done, busy, in_ready,
                         e_we, e_bus, e_done, mload);
            end
            if (done && dcyc < 0) dcyc = c + 1;
        end
        checks++;
        if (dcyc != WT + 4) begin
            errors++;
            $display("FAIL stall_done got cycle %0d want %0d",
                     dcyc, WT + 4);
        end
    endtask

    task automatic test_restart_ignored();
        int dcyc = -1;
        step(1'b1, 1'b0, 1'b0, '0);
        for (int c = 1; c <= WT + 3; c++) begin
            step(c == 6, c <= WT, 1'b0, N'(c));
            checks++;
            if ({we, bus, done, busy, in_ready} !==
                {e_we, e_bus, e_done, mload, mload}) begin
                errors++;
                $display("FAIL restart cyc=%0d got we=%b bus=%0d d=%b b=%b want we=%b bus=%0d d=%b b=%b",
                         c + 1, we, bus, done, busy, in_ready,
                         e_we, e_bus, e_done, mload);
            end
            if (done && dcyc < 0) dcyc = c + 1;
        end
        checks++;
        if (dcyc != WT + 1) begin
            errors++;
            $display("FAIL restart_done got cycle %0d want %0d",
                     dcyc, WT + 1);
        end
    endtask

    task automatic test_rst_mid();
        step(1'b1, 1'b0, 1'b0, '0);
        for (int c = 1; c <= 4; c++) step(1'b0, 1'b1, 1'b0, N'(c));
        step(1'b1, 1'b1, 1'b1, N'(99));
        checks++;
        if ({we, busy, in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid got we=%b busy=%b rdy=%b want 0 0 0",
                     we, busy, in_ready);
        end
        step(1'b1, 1'b0, 1'b0, '0);
        for (int c = 1; c <= WT + 2; c++) begin
            step(1'b0, 1'b1, 1'b0, N'($urandom));
            checks++;
            if ({we, bus, done, busy, in_ready} !==
                {e_we, e_bus, e_done, mload, mload}) begin
                errors++;
                $display("FAIL rst_reload cyc=%0d got we=%b bus=%0h d=%b b=%b want we=%b bus=%0h d=%b b=%b",
                         c, we, bus, done, busy, in_ready,
                         e_we, e_bus, e_done, mload);
            end
            if (c == 1) begin
                checks++;
                if (we !== ND'(1) << (ND - 1)) begin
                    errors++;
                    $display("FAIL rst_reload_first got we=%b want %b",
                             we, ND'(1) << (ND - 1));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(($urandom % 6) == 0, ($urandom % 3) != 0,
                 ($urandom % 70) == 0, N'($urandom));
            checks++;
            if ({we, bus, done, busy, in_ready} !==
                {e_we, e_bus, e_done, mload, mload}) begin
                errors++;
                $display("FAIL random c=%0d got we=%b bus=%0h d=%b b=%b want we=%b bus=%0h d=%b b=%b",
                         c, we, bus, done, busy, in_ready,
                         e_we, e_bus, e_done, mload);
            end
        end
    endtask

    initial begin
        for (int nd_i = ND - 1; nd_i >= 0; nd_i--) begin
            for (int k = 0; k < fanin(nd_i, SX, SL1, SL) + BIAS; k++) begin
                seqn.push_back(nd_i);
            end
        end
        test_reset();
        test_full_load();
        test_stall();
        test_restart_ignored();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
